// File: rtl/alpha_display_ctrl.sv
// alpha_display_ctrl
//   Multi-digit 14-segment alphabetic display controller. Characters are
//   appended to a message buffer and shown on DIGITS time-multiplexed
//   positions, either statically (message head) or scrolling right-to-left
//   through the message followed by DIGITS blanks.
//
// Ports
//   clk       : single clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   wr_en     : append wr_char to the message (ignored while full)
//   wr_char   : 5-bit letter code, 0-25 = A-Z, 26-31 = blank
//   clear     : empty the message and reset the scroll offset (beats wr_en)
//   scroll_en : 1 = scroll mode, 0 = static mode
//   blank     : force seg and dig_en to zero, timing keeps running
//   seg       : registered segment pattern, s[0:13], active-high
//   dig_en    : registered one-hot digit enable, bit 0 = leftmost digit
//   msg_len   : number of stored characters
//   full      : msg_len == MSG_DEPTH

module alpha_display_ctrl #(
    parameter int DIGITS      = 4,
    parameter int MSG_DEPTH   = 16,
    parameter int REFRESH_DIV = 1000,
    parameter int SCROLL_DIV  = 50
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [4:0]                     wr_char,
    input  logic                           clear,
    input  logic                           scroll_en,
    input  logic                           blank,
    output logic [0:13]                    seg,
    output logic [DIGITS-1:0]              dig_en,
    output logic [$clog2(MSG_DEPTH+1)-1:0] msg_len,
    output logic                           full
);

    localparam int LW = $clog2(MSG_DEPTH + 1);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
    // One spare bit so offset + index (< 2L) never overflows.
    localparam int AW = $clog2(MSG_DEPTH + DIGITS) + 1;

    logic [4:0]    msg_buf [MSG_DEPTH];
    logic [PW-1:0] presc;
    logic [IW-1:0] dig_idx;
    logic [FW-1:0] frame_cnt;
    logic [AW-1:0] offset;

    logic          presc_tc;
    logic          idx_wrap;
    logic          scroll_step;
    logic [AW-1:0] len_ext;
    logic [AW-1:0] seq_len;
    logic [AW-1:0] pos;
    logic [4:0]    sel_code;
    logic [0:13]   dec_seg;
    logic          do_write;

    assign full        = (msg_len == LW'(MSG_DEPTH));
    assign do_write    = wr_en && !full && !clear;
    assign presc_tc    = (presc == PW'(REFRESH_DIV - 1));
    assign idx_wrap    = presc_tc && (dig_idx == IW'(DIGITS - 1));
    assign scroll_step = idx_wrap && (frame_cnt == FW'(SCROLL_DIV - 1));
    assign len_ext     = AW'(msg_len);
    // Virtual sequence: message followed by DIGITS blank positions.
    assign seq_len     = len_ext + AW'(DIGITS);

    // Refresh prescaler, digit index and frame counter run freely; blank
    // does not stop them so release resumes mid-sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            dig_idx   <= '0;
            frame_cnt <= '0;
        end else begin
            if (presc_tc) begin
                presc <= '0;
                if (dig_idx == IW'(DIGITS - 1))
                    dig_idx <= '0;
                else
                    dig_idx <= dig_idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            if (idx_wrap) begin
                if (frame_cnt == FW'(SCROLL_DIV - 1))
                    frame_cnt <= '0;
                else
                    frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Scroll offset. A write only lengthens the sequence, so an offset that
    // was valid before a write remains valid after it.
    always_ff @(posedge clk) begin
        if (rst || clear || !scroll_en) begin
            offset <= '0;
        end else if (scroll_step) begin
            if (offset >= seq_len - AW'(1))
                offset <= '0;
            else
                offset <= offset + 1'b1;
        end
    end

    // Message length; clear has priority over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst || clear)
            msg_len <= '0;
        else if (wr_en && !full)
            msg_len <= msg_len + 1'b1;
    end

    // Buffer storage is never erased; entries beyond msg_len are ignored.
    always_ff @(posedge clk) begin
        if (!rst && do_write)
            msg_buf[msg_len[BW-1:0]] <= wr_char;
    end

    // Character selection for the currently indexed digit. offset < L and
    // index < DIGITS <= L, so one conditional subtract performs the modulo.
    always_comb begin
        pos      = AW'(dig_idx);
        sel_code = 5'd31;
        if (scroll_en) begin
            pos = offset + AW'(dig_idx);
            if (pos >= seq_len)
                pos = pos - seq_len;
        end
        if (pos < len_ext)
            sel_code = msg_buf[pos[BW-1:0]];
    end

    alphadecode u_decode (
        .code (sel_code),
        .s    (dec_seg)
    );

    // Output registers: enable and pattern change together on one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg    <= '0;
            dig_en <= '0;
        end else if (blank) begin
            seg    <= '0;
            dig_en <= '0;
        end else begin
            seg    <= dec_seg;
            dig_en <= DIGITS'(1) << dig_idx;
        end
    end

endmodule

// alphadecode
//   Letter decoder: code 0-25 -> A-Z on a 14-segment digit, 26-31 -> dark.
//   Segment order s[0..13] = a, b, c, d, e, f, g1, g2, h, i, j, k, l, m.
// Ports
//   code : 5-bit letter code
//   s    : active-high segment vector
module alphadecode (
    input  logic [4:0]  code,
    output logic [0:13] s
);

    logic [13:0] f;

    // Font kept as bit k = segment k, then unpacked into s[0:13].
    always_comb begin
        f = 14'h0000;
        case (code)
            5'd0:  f = 14'h00F7;
            5'd1:  f = 14'h128F;
            5'd2:  f = 14'h0039;
            5'd3:  f = 14'h120F;
            5'd4:  f = 14'h00F9;
            5'd5:  f = 14'h0071;
            5'd6:  f = 14'h00BD;
            5'd7:  f = 14'h00F6;
            5'd8:  f = 14'h1209;
            5'd9:  f = 14'h001E;
            5'd10: f = 14'h2470;
            5'd11: f = 14'h0038;
            5'd12: f = 14'h0536;
            5'd13: f = 14'h2136;
            5'd14: f = 14'h003F;
            5'd15: f = 14'h00F3;
            5'd16: f = 14'h203F;
            5'd17: f = 14'h20F3;
            5'd18: f = 14'h00ED;
            5'd19: f = 14'h1201;
            5'd20: f = 14'h003E;
            5'd21: f = 14'h0C30;
            5'd22: f = 14'h2836;
            5'd23: f = 14'h2D00;
            5'd24: f = 14'h1500;
            5'd25: f = 14'h0C09;
            default: f = 14'h0000;
        endcase
        s = '0;
        for (int k = 0; k < 14; k++)
            s[k] = f[k];
    end

endmodule

// File: tb/tb_alpha_display_ctrl.sv
// tb_alpha_display_ctrl
//   Directed and randomized stimulus for alpha_display_ctrl, checked every
//   cycle against a behavioural model that derives digit index and scroll
//   steps from elapsed cycle count and keeps the message as a queue.
module tb_alpha_display_ctrl;

    localparam int D = 4;
    localparam int M = 8;
    localparam int R = 2;
    localparam int S = 1;
    localparam int LW = $clog2(M + 1);

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [4:0]    wr_char;
    logic          clear;
    logic          scroll_en;
    logic          blank;
    logic [0:13]   seg;
    logic [D-1:0]  dig_en;
    logic [LW-1:0] msg_len;
    logic          full;

    alpha_display_ctrl #(
        .DIGITS      (D),
        .MSG_DEPTH   (M),
        .REFRESH_DIV (R),
        .SCROLL_DIV  (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_char   (wr_char),
        .clear     (clear),
        .scroll_en (scroll_en),
        .blank     (blank),
        .seg       (seg),
        .dig_en    (dig_en),
        .msg_len   (msg_len),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 14-segment font, bit k = segment k (a,b,c,d,e,f,g1,g2,h,i,j,k,l,m).
    logic [13:0] font [26] = '{
        14'h00F7, 14'h128F, 14'h0039, 14'h120F, 14'h00F9, 14'h0071,
        14'h00BD, 14'h00F6, 14'h1209, 14'h001E, 14'h2470, 14'h0038,
        14'h0536, 14'h2136, 14'h003F, 14'h00F3, 14'h203F, 14'h20F3,
        14'h00ED, 14'h1201, 14'h003E, 14'h0C30, 14'h2836, 14'h2D00,
        14'h1500, 14'h0C09
    };

    int vectors;
    int miscompares;

    // Reference model state
    int          t;
    int          off;
    logic [4:0]  msg [$];
    logic [13:0] exp_seg;
    logic [D-1:0] exp_dig;
    int          exp_len;

    // Compare all observable outputs against the model's expectations.
    task automatic checkOutput();
        logic [13:0] seg_v;
        for (int k = 0; k < 14; k++) seg_v[k] = seg[k];
        vectors++;
        assert (seg_v === exp_seg) else begin
            miscompares++;
            $error("[TB] FAIL seg t=%0d observed=%h expected=%h", t, seg_v, exp_seg);
        end
        vectors++;
        assert (dig_en === exp_dig) else begin
            miscompares++;
            $error("[TB] FAIL dig_en t=%0d observed=%b expected=%b", t, dig_en, exp_dig);
        end
        vectors++;
        assert (msg_len === LW'(exp_len)) else begin
            miscompares++;
            $error("[TB] FAIL msg_len t=%0d observed=%0d expected=%0d", t, msg_len, exp_len);
        end
        vectors++;
        assert (full === (exp_len == M)) else begin
            miscompares++;
            $error("[TB] FAIL full t=%0d observed=%b expected=%b", t, full, (exp_len == M));
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then
    // check the outputs just after the edge.
    task automatic applyStimulus(input bit r, input bit w, input logic [4:0] c,
                                 input bit cl, input bit sc, input bit bl);
        int idx;
        int len;
        int seqlen;
        int p;
        logic [4:0] code;
        rst       = r;
        wr_en     = w;
        wr_char   = c;
        clear     = cl;
        scroll_en = sc;
        blank     = bl;
        if (r) begin
            t       = 0;
            off     = 0;
            msg.delete();
            exp_seg = '0;
            exp_dig = '0;
        end else begin
            idx    = (t / R) % D;
            len    = msg.size();
            seqlen = len + D;
            p      = sc ? (off + idx) % seqlen : idx;
            code   = (p < len) ? msg[p] : 5'd31;
            exp_dig = '0;
            exp_seg = '0;
            if (!bl) begin
                exp_dig[idx] = 1'b1;
                if (code < 26) exp_seg = font[code];
            end
            if (cl || !sc)
                off = 0;
            else if ((t + 1) % (D * R * S) == 0)
                off = (off + 1) % seqlen;
            if (cl)
                msg.delete();
            else if (w && len < M)
                msg.push_back(c);
            t++;
        end
        exp_len = msg.size();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        bit sc_state;
        bit bl_state;
        vectors     = 0;
        miscompares = 0;
        t = 0; off = 0; exp_len = 0; exp_seg = '0; exp_dig = '0;
        rst = 1'b1; wr_en = 1'b0; wr_char = '0; clear = 1'b0;
        scroll_en = 1'b0; blank = 1'b0;

        $display("[TB] reset and empty-message refresh walk");
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0);
        repeat (16) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] static display HI");
        applyStimulus(0, 1, 5'd7, 0, 0, 0);
        applyStimulus(0, 1, 5'd8, 0, 0, 0);
        repeat (16) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] fill, overflow, clear with simultaneous write");
        applyStimulus(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++)
            applyStimulus(0, 1, 5'($urandom_range(0, 25)), 0, 0, 0);
        repeat (8) applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 5'd3, 1, 0, 0);
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] scroll wrap with AB");
        applyStimulus(0, 1, 5'd0, 0, 0, 0);
        applyStimulus(0, 1, 5'd1, 0, 0, 0);
        repeat (8 * 8) applyStimulus(0, 0, 0, 0, 1, 0);
        repeat (16) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] blank override during scroll");
        repeat (10) applyStimulus(0, 0, 0, 0, 1, 0);
        repeat (24) applyStimulus(0, 0, 0, 0, 1, 1);
        repeat (24) applyStimulus(0, 0, 0, 0, 1, 0);

        $display("[TB] reset mid-scroll");
        applyStimulus(0, 0, 0, 1, 1, 0);
        applyStimulus(0, 1, 5'd0, 0, 1, 0);
        applyStimulus(0, 1, 5'd1, 0, 1, 0);
        repeat (26) applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 5'd4, 0, 1, 0);
        repeat (16) applyStimulus(0, 0, 0, 0, 1, 0);

        $display("[TB] randomized traffic");
        sc_state = 1'b1;
        bl_state = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) sc_state = ~sc_state;
            if ($urandom_range(0, 39) == 0) bl_state = ~bl_state;
            applyStimulus($urandom_range(0, 499) == 0,
                          $urandom_range(0, 5) == 0,
                          5'($urandom_range(0, 31)),
                          $urandom_range(0, 79) == 0,
                          sc_state, bl_state);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
